fifo_wr_arbiter: RTL and testbench

//  Shares one FIFO write port between NUM_REQ stream sources (data_gen instances).

---
 rtl/data_gen_pkg.sv | 38 +++
 rtl/fifo_wr_arbiter_if.sv | 24 ++
 rtl/rr_arbiter.sv | 23 ++
 rtl/fifo_wr_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_wr_arbiter.sv | 326 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_gen_pkg.sv
// Shared types and helpers for the data generator / FIFO write arbiter slice.
// Holds the arbiter FSM state type and the round-robin pick function.
package data_gen_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2,
    DONE  = 2'd3
  } arb_state_t;

  localparam int MAX_REQ = 16;

  // Returns {found, idx}: first set bit of valid at or after ptr, wrapping at num.
  // ptr < num is assumed, so ptr + i never needs more than one subtraction of num.
  function automatic logic [4:0] rr_pick(input logic [15:0] valid,
                                         input logic [3:0]  ptr,
                                         input logic [4:0]  num);
    logic [4:0] res;
    logic [4:0] sum;
    logic [4:0] idx;
    logic       hit;
    res = 5'd0;
    hit = 1'b0;
    for (int i = 0; i < MAX_REQ; i++) begin
      sum = {1'b0, ptr} + 5'(i);
      idx = (sum >= num) ? (sum - num) : sum;
      if (!hit && (5'(i) < num) && valid[idx[3:0]]) begin
        res = {1'b1, idx[3:0]};
        hit = 1'b1;
      end else begin
        res = res;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Source streams plus FIFO write port shared by the arbiter.
// slave is the arbiter side; master is the sources/FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ*WIDTH-1:0] s_tdata;
  logic [NUM_REQ-1:0]       s_tvalid;
  logic [NUM_REQ-1:0]       s_tlast;
  logic [NUM_REQ-1:0]       s_tready;
  logic                     fifo_wr_en;
  logic [WIDTH-1:0]         fifo_wr_data;
  logic                     fifo_full;

  modport master (
    output s_tdata, s_tvalid, s_tlast, fifo_full,
    input  s_tready, fifo_wr_en, fifo_wr_data
  );

  modport slave (
    input  s_tdata, s_tvalid, s_tlast, fifo_full,
    output s_tready, fifo_wr_en, fifo_wr_data
  );
endinterface

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requesting source at or after ptr.
module rr_arbiter
  import data_gen_pkg::*;
#(
  parameter int  NUM_REQ = 4,
  localparam int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_vld
);

  logic [4:0] pick_s;

  // Widen to the helper's fixed 16-source form and narrow the result back
  always_comb begin
    pick_s  = rr_pick(16'(req), 4'(ptr), 5'(NUM_REQ));
    gnt_vld = pick_s[4];
    gnt_idx = IDX_W'(pick_s[3:0]);
  end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: packet-granular round-robin sharing of one FIFO write port.
// Define FIFO_WR_ARB_STATS_EN to add per-source packet counters on pkt_stat.
module fifo_wr_arbiter
  import data_gen_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int NUM_REQ = 4
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  ap_start,
  output logic                  ap_done,
  output logic                  ap_idle,
  output logic                  ap_ready,
  input  logic [31:0]           pkt_total,
`ifdef FIFO_WR_ARB_STATS_EN
  output logic [NUM_REQ*32-1:0] pkt_stat,
`endif
  fifo_wr_arbiter_if.slave      bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  arb_state_t         state_r;
  arb_state_t         state_s;
  logic [IDX_W-1:0]   grant_r;
  logic [IDX_W-1:0]   rr_ptr_r;
  logic [IDX_W-1:0]   rr_next_s;
  logic [IDX_W-1:0]   gnt_idx_s;
  logic               gnt_vld_s;
  logic [31:0]        pkt_cnt_r;
  logic [31:0]        pkt_total_q_r;
  logic [31:0]        pkt_cnt_inc_s;
  logic [WIDTH-1:0]   src_data_s [NUM_REQ];
  logic [NUM_REQ-1:0] s_tready_s;
  logic [WIDTH-1:0]   wr_data_s;
  logic               open_s;
  logic               beat_s;
  logic               last_beat_s;
  logic               start_s;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req     (bus.s_tvalid),
    .ptr     (rr_ptr_r),
    .gnt_idx (gnt_idx_s),
    .gnt_vld (gnt_vld_s)
  );

  // Unpack the source lanes and derive the per-cycle handshake terms
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      src_data_s[i] = bus.s_tdata[i*WIDTH +: WIDTH];
    end
    open_s        = (state_r == GRANT) && !bus.fifo_full;
    beat_s        = open_s && bus.s_tvalid[grant_r];
    last_beat_s   = beat_s && bus.s_tlast[grant_r];
    start_s       = (state_r == IDLE) && ap_start;
    pkt_cnt_inc_s = pkt_cnt_r + 32'd1;
    rr_next_s     = (grant_r == IDX_W'(NUM_REQ - 1)) ? '0 : (grant_r + IDX_W'(1));
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (ap_start) begin
          state_s = (pkt_total == 32'd0) ? DONE : ARB;
        end else begin
          state_s = IDLE;
        end
      end
      ARB: begin
        if (gnt_vld_s) begin
          state_s = GRANT;
        end else begin
          state_s = ARB;
        end
      end
      GRANT: begin
        if (last_beat_s) begin
          state_s = (pkt_cnt_inc_s == pkt_total_q_r) ? DONE : ARB;
        end else begin
          state_s = GRANT;
        end
      end
      DONE:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // Status flags and the combinational grant mux toward the FIFO
  always_comb begin
    ap_idle             = (state_r == IDLE);
    ap_ready            = start_s;
    ap_done             = (state_r == DONE);
    s_tready_s          = '0;
    s_tready_s[grant_r] = open_s;
    wr_data_s           = beat_s ? src_data_s[grant_r] : '0;
  end

  assign bus.s_tready     = s_tready_s;
  assign bus.fifo_wr_en   = beat_s;
  assign bus.fifo_wr_data = wr_data_s;

  // State, grant, round-robin pointer and run counters
  always_ff @(posedge ap_clk) begin
    if (ap_rst) begin
      state_r       <= IDLE;
      grant_r       <= '0;
      rr_ptr_r      <= '0;
      pkt_cnt_r     <= 32'd0;
      pkt_total_q_r <= 32'd0;
    end else begin
      state_r <= state_s;
      if (start_s) begin
        pkt_total_q_r <= pkt_total;
        pkt_cnt_r     <= 32'd0;
        rr_ptr_r      <= '0;
      end else if ((state_r == ARB) && gnt_vld_s) begin
        grant_r <= gnt_idx_s;
      end else if (last_beat_s) begin
        rr_ptr_r  <= rr_next_s;
        pkt_cnt_r <= pkt_cnt_inc_s;
      end else begin
        pkt_cnt_r <= pkt_cnt_r;
      end
    end
  end

`ifdef FIFO_WR_ARB_STATS_EN
  logic [31:0] stat_r [NUM_REQ];

  // Per-source packet counts for the current run; held after completion
  always_ff @(posedge ap_clk) begin
    if (ap_rst || start_s) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        stat_r[i] <= 32'd0;
      end
    end else if (last_beat_s) begin
      stat_r[grant_r] <= stat_r[grant_r] + 32'd1;
    end else begin
      stat_r[grant_r] <= stat_r[grant_r];
    end
  end

  // Pack the counters onto the output port
  always_comb begin
    for (int i = 0; i < NUM_REQ; i++) begin
      pkt_stat[i*32 +: 32] = stat_r[i];
    end
  end
`endif

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: directed scenarios plus randomized runs
// compared every cycle against a behavioural model of the run rules.
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 32;
  localparam int N     = 4;

  logic        ap_clk    = 1'b0;
  logic        ap_rst    = 1'b1;
  logic        ap_start  = 1'b0;
  logic [31:0] pkt_total = 32'd0;
  logic        ap_done;
  logic        ap_idle;
  logic        ap_ready;

  fifo_wr_arbiter_if #(.WIDTH(WIDTH), .NUM_REQ(N)) bus ();
`ifdef FIFO_WR_ARB_STATS_EN
  logic [N*32-1:0] pkt_stat;
`endif

  fifo_wr_arbiter #(.WIDTH(WIDTH), .NUM_REQ(N)) dut (
    .ap_clk    (ap_clk),
    .ap_rst    (ap_rst),
    .ap_start  (ap_start),
    .ap_done   (ap_done),
    .ap_idle   (ap_idle),
    .ap_ready  (ap_ready),
    .pkt_total (pkt_total),
`ifdef FIFO_WR_ARB_STATS_EN
    .pkt_stat  (pkt_stat),
`endif
    .bus       (bus)
  );

  always #5 ap_clk = ~ap_clk;

  int n_total = 0;
  int n_bad   = 0;

  // Source beat queues; each beat is {src, packet id, beat index}
  logic [WIDTH-1:0] dq [N][$];
  logic             lq [N][$];
  logic [N-1:0]     offer  = '0;
  logic [N-1:0]     src_on = '0;
  int               rate   = 100;
  int               full_prob = 0;
  logic             full_v = 1'b0;
  bit               start_noise = 1'b0;

  // Reference model of a run
  int     m_phase = 0;   // 0 idle, 1 arbitrate, 2 forwarding packet, 3 done
  int     m_g = 0;
  int     m_ptr = 0;
  longint m_cnt = 0;
  longint m_total = 0;
  int     m_stat [N];

  int           cyc = 0;
  int           wr_cnt = 0;
  int           last_tl_cyc = 0;
  int           done_cyc = 0;
  int           pid = 0;
  bit           done_seen = 1'b0;
  bit           chk_en = 1'b0;
  int           pkt_log [$];
  logic [N-1:0] wr_src_mask = '0;
  logic         o_idle, o_ready, o_done, o_wr;
  logic [N-1:0] o_tready;

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic load_pkts(input int src, input int npk, input int nbeats);
    for (int p = 0; p < npk; p++) begin
      int nb;
      nb = (nbeats > 0) ? nbeats : int'($urandom_range(4, 1));
      for (int b = 0; b < nb; b++) begin
        dq[src].push_back(WIDTH'((src << 28) | ((pid & 32'hFFF) << 16) | b));
        lq[src].push_back(b == nb - 1);
      end
      pid++;
    end
  endtask

  task automatic flush();
    for (int i = 0; i < N; i++) begin
      dq[i].delete();
      lq[i].delete();
      m_stat[i] = m_stat[i];
    end
    offer = '0;
  endtask

  // One clock cycle: drive sources, compare outputs with the model, advance both
  task automatic step();
    logic [N-1:0]       v, l, acc, e_rdy;
    logic [N*WIDTH-1:0] d;
    logic               e_wr;
    logic [WIDTH-1:0]   e_data;
    logic [N*32-1:0]    e_stat;
    bit                 found;
    for (int i = 0; i < N; i++) begin
      if (!offer[i] && src_on[i] && dq[i].size() > 0 && int'($urandom_range(99)) < rate)
        offer[i] = 1'b1;
      v[i] = offer[i];
      d[i*WIDTH +: WIDTH] = offer[i] ? dq[i][0] : WIDTH'($urandom);
      l[i] = offer[i] ? lq[i][0] : 1'($urandom_range(1));
    end
    if (full_prob > 0) full_v = (int'($urandom_range(99)) < full_prob);
    bus.s_tvalid  = v;
    bus.s_tdata   = d;
    bus.s_tlast   = l;
    bus.fifo_full = full_v;
    #1;
    e_rdy  = '0;
    e_wr   = 1'b0;
    e_data = '0;
    if (m_phase == 2 && !full_v) begin
      e_rdy[m_g] = 1'b1;
      e_wr       = v[m_g];
    end
    if (e_wr) e_data = dq[m_g][0];
    for (int i = 0; i < N; i++) e_stat[i*32 +: 32] = 32'(m_stat[i]);
    o_idle = ap_idle; o_ready = ap_ready; o_done = ap_done;
    o_tready = bus.s_tready; o_wr = bus.fifo_wr_en;
    if (chk_en) begin
      check("ap_idle", ap_idle, m_phase == 0);
      check("ap_ready", ap_ready, (m_phase == 0) && ap_start);
      check("ap_done", ap_done, m_phase == 3);
      check("s_tready", bus.s_tready, e_rdy);
      check("fifo_wr_en", bus.fifo_wr_en, e_wr);
      check("fifo_wr_data", bus.fifo_wr_data, e_data);
`ifdef FIFO_WR_ARB_STATS_EN
      check("pkt_stat", pkt_stat, e_stat);
`endif
    end
    acc = v & bus.s_tready;
    if (bus.fifo_wr_en) begin
      wr_cnt++;
      wr_src_mask |= bus.s_tready;
    end
    if (ap_done) begin
      done_seen = 1'b1;
      done_cyc  = cyc;
    end
    @(posedge ap_clk);
    for (int i = 0; i < N; i++) begin
      if (acc[i]) begin
        if (lq[i][0]) begin
          pkt_log.push_back(i);
          last_tl_cyc = cyc;
        end
        void'(dq[i].pop_front());
        void'(lq[i].pop_front());
        offer[i] = 1'b0;
      end
    end
    if (ap_rst) begin
      m_phase = 0; m_ptr = 0; m_cnt = 0; m_total = 0;
      for (int i = 0; i < N; i++) m_stat[i] = 0;
    end else if (m_phase == 0) begin
      if (ap_start) begin
        m_total = longint'(pkt_total);
        m_cnt   = 0;
        m_ptr   = 0;
        for (int i = 0; i < N; i++) m_stat[i] = 0;
        m_phase = (m_total == 0) ? 3 : 1;
      end
    end else if (m_phase == 1) begin
      found = 1'b0;
      for (int k = 0; k < N; k++) begin
        if (!found && v[(m_ptr + k) % N]) begin
          m_g     = (m_ptr + k) % N;
          m_phase = 2;
          found   = 1'b1;
        end
      end
    end else if (m_phase == 2) begin
      if (e_wr && l[m_g]) begin
        m_stat[m_g]++;
        m_cnt++;
        m_ptr   = (m_g + 1) % N;
        m_phase = (m_cnt == m_total) ? 3 : 1;
      end
    end else begin
      m_phase = 0;
    end
    cyc++;
    #1;
  endtask

  task automatic start_run(input logic [31:0] total);
    pkt_total   = total;
    ap_start    = 1'b1;
    done_seen   = 1'b0;
    wr_cnt      = 0;
    wr_src_mask = '0;
    pkt_log.delete();
    step();
    ap_start = 1'b0;
`ifdef FIFO_WR_ARB_STATS_EN
    check("stat_clear_on_start", pkt_stat, 128'd0);
`endif
  endtask

  task automatic wait_done(input int budget);
    for (int k = 0; k < budget && !done_seen; k++) begin
      if (start_noise) begin
        ap_start  = ($urandom_range(7) == 0);
        pkt_total = $urandom;
      end
      step();
    end
    ap_start = 1'b0;
    check("run_completes", done_seen, 1'b1);
  endtask

  initial begin
    int stall;
    int tot;
    for (int i = 0; i < N; i++) m_stat[i] = 0;
    bus.s_tvalid = '0; bus.s_tdata = '0; bus.s_tlast = '0; bus.fifo_full = 1'b0;
    #1;
    step();
    step();
    ap_rst = 1'b0;
    chk_en = 1'b1;
    step();
    check("rst_idle", o_idle, 1'b1);
    check("rst_ready", o_ready, 1'b0);
    check("rst_done", o_done, 1'b0);
    check("rst_tready", o_tready, 4'b0000);
    check("rst_wr_en", o_wr, 1'b0);

    // All sources busy, 2-beat packets, 8 packets per run
    flush(); src_on = 4'b1111; rate = 100;
    for (int i = 0; i < N; i++) load_pkts(i, 2, 2);
    start_run(32'd8);
    wait_done(200);
    check("t1_pkts", pkt_log.size(), 8);
    for (int i = 0; i < pkt_log.size() && i < 8; i++) check("t1_grant_order", pkt_log[i], i % N);
    check("t1_writes", wr_cnt, 16);
    check("t1_done_lat", done_cyc - last_tl_cyc, 1);
`ifdef FIFO_WR_ARB_STATS_EN
    check("t6_stat", pkt_stat, {4{32'd2}});
`endif

    // Single active source, 4-beat packets
    flush(); src_on = 4'b0100;
    for (int i = 0; i < N; i++) load_pkts(i, 3, 4);
    start_run(32'd3);
    wait_done(200);
    check("t2_writes", wr_cnt, 12);
    check("t2_src_mask", wr_src_mask, 4'b0100);

    // FIFO full for five cycles in the middle of a packet
    flush(); src_on = 4'b0010;
    load_pkts(1, 1, 10);
    start_run(32'd1);
    for (int k = 0; k < 50 && wr_cnt < 3; k++) step();
    full_v = 1'b1; stall = 0;
    repeat (5) begin
      step();
      if (!o_wr && o_tready == '0) stall++;
    end
    full_v = 1'b0;
    wait_done(100);
    check("t3_stall_cycles", stall, 5);
    check("t3_writes", wr_cnt, 10);
    check("t3_src_mask", wr_src_mask, 4'b0010);

    // Zero-packet run
    flush();
    start_run(32'd0);
    check("t4_ready_c0", o_ready, 1'b1);
    step();
    check("t4_done_c1", o_done, 1'b1);
    step();
    check("t4_idle_c2", o_idle, 1'b1);
    check("t4_writes", wr_cnt, 0);

    // Reset in the middle of a granted packet, then a clean single-packet run
    flush(); src_on = 4'b1111;
    for (int i = 0; i < N; i++) load_pkts(i, 1, 8);
    start_run(32'd4);
    for (int k = 0; k < 50 && wr_cnt < 3; k++) step();
    ap_rst = 1'b1;
    step();
    ap_rst = 1'b0;
    step();
    check("t5_idle_after_rst", o_idle, 1'b1);
    check("t5_tready_after_rst", o_tready, 4'b0000);
    check("t5_no_done", done_seen, 1'b0);
    flush();
    for (int i = 0; i < N; i++) load_pkts(i, 1, 2);
    start_run(32'd1);
    wait_done(100);
    check("t5_pkts", pkt_log.size(), 1);
    if (pkt_log.size() > 0) check("t5_first_grant", pkt_log[0], 0);

    // Randomized runs: gaps, backpressure, packet lengths, ignored ap_start
    for (int r = 0; r < 20; r++) begin
      flush();
      src_on    = 4'($urandom_range(15, 1));
      rate      = int'($urandom_range(100, 20));
      full_prob = int'($urandom_range(40));
      tot       = int'($urandom_range(6, 1));
      for (int i = 0; i < N; i++) if (src_on[i]) load_pkts(i, tot, 0);
      start_run(32'(tot));
      start_noise = 1'b1;
      wait_done(3000);
      start_noise = 1'b0;
      full_prob = 0;
      full_v = 1'b0;
      check("rand_pkts", pkt_log.size(), tot);
      step();
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end
endmodule
